// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// dmem_arbiter_if : request/grant/read-return bundle between two masters,
//                   the arbiter and the single-port dmem.   Rev 1.0
// ============================================================================
interface dmem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              p0_req;
  logic              p0_wren;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_data;
  logic              p0_gnt;
  logic              p0_rvalid;
  logic [DATA_W-1:0] p0_q;

  logic              p1_req;
  logic              p1_wren;
  logic              p1_lock;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_data;
  logic              p1_gnt;
  logic              p1_rvalid;
  logic [DATA_W-1:0] p1_q;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;

  // Arbiter side.
  modport slave (
    input  p0_req, p0_wren, p0_addr, p0_data,
    output p0_gnt, p0_rvalid, p0_q,
    input  p1_req, p1_wren, p1_lock, p1_addr, p1_data,
    output p1_gnt, p1_rvalid, p1_q,
    output mem_address, mem_data, mem_wren,
    input  mem_q
  );

  // Requesters plus the memory they share.
  modport master (
    output p0_req, p0_wren, p0_addr, p0_data,
    input  p0_gnt, p0_rvalid, p0_q,
    output p1_req, p1_wren, p1_lock, p1_addr, p1_data,
    input  p1_gnt, p1_rvalid, p1_q,
    input  mem_address, mem_data, mem_wren,
    output mem_q
  );
endinterface : dmem_arbiter_if
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_arbiter : two-port dmem arbiter, round-robin ties, port-1 lock for RMW.
//   DMEM_ARB_FIXED_PRIO_EN : port 0 always wins ties.            Rev 1.0
// ============================================================================
module dmem_arbiter (
  input  wire             clk_i,
  input  wire             rst_i,
  dmem_arbiter_if.slave   bus
);

  typedef enum logic [0:0] {
    S_ARB    = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  localparam logic [1:0] c_OWN_NONE = 2'd0;
  localparam logic [1:0] c_OWN_P0   = 2'd1;
  localparam logic [1:0] c_OWN_P1   = 2'd2;

  state_t     state_q;
  logic [1:0] rd_owner_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
  logic       last_winner_q;
`endif

  logic w_win0;
  logic w_win1;

  always_comb begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
    w_win0 = (state_q == S_ARB) & bus.p0_req;
`else
    w_win0 = (state_q == S_ARB) & bus.p0_req & (~bus.p1_req | last_winner_q);
`endif
    // Port 1 takes every cycle port 0 does not win, including all of LOCKED.
    w_win1 = bus.p1_req & ~w_win0;
  end

  assign bus.p0_gnt      = w_win0 & ~rst_i;
  assign bus.p1_gnt      = w_win1 & ~rst_i;
  assign bus.mem_address = w_win1 ? bus.p1_addr : bus.p0_addr;
  assign bus.mem_data    = w_win1 ? bus.p1_data : bus.p0_data;
  assign bus.mem_wren    = ~rst_i & ((w_win0 & bus.p0_wren) | (w_win1 & bus.p1_wren));

  assign bus.p0_rvalid   = (rd_owner_q == c_OWN_P0);
  assign bus.p1_rvalid   = (rd_owner_q == c_OWN_P1);
  assign bus.p0_q        = (rd_owner_q == c_OWN_P0) ? bus.mem_q : '0;
  assign bus.p1_q        = (rd_owner_q == c_OWN_P1) ? bus.mem_q : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_ARB;
      rd_owner_q    <= c_OWN_NONE;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_winner_q <= 1'b1;
`endif
    end else begin
      if (w_win0) begin
        rd_owner_q <= bus.p0_wren ? c_OWN_NONE : c_OWN_P0;
      end else if (w_win1) begin
        rd_owner_q <= bus.p1_wren ? c_OWN_NONE : c_OWN_P1;
      end else begin
        rd_owner_q <= c_OWN_NONE;
      end

`ifndef DMEM_ARB_FIXED_PRIO_EN
      if (w_win0) begin
        last_winner_q <= 1'b0;
      end else if (w_win1) begin
        last_winner_q <= 1'b1;
      end
`endif

      case (state_q)
        S_ARB: begin
          if (w_win1 && bus.p1_lock) begin
            state_q <= S_LOCKED;
          end
        end
        S_LOCKED: begin
          if (!bus.p1_lock) begin
            state_q <= S_ARB;
          end
        end
        default: state_q <= S_ARB;
      endcase
    end
  end

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dmem_arbiter : directed self-checking bench for dmem_arbiter with a
//                   one-cycle registered-read memory model.       Rev 1.0
// ============================================================================
module tb_dmem_arbiter;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  localparam bit c_FIXED = 1'b1;
`else
  localparam bit c_FIXED = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  logic        ld_en;
  logic [11:0] ld_addr;
  logic [31:0] ld_data;
  logic [31:0] mem [0:4095];

  dmem_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  dmem_arbiter u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (bus.mem_wren) begin
      mem[bus.mem_address] <= bus.mem_data;
    end
    bus.mem_q <= mem[bus.mem_address];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_p0(input logic req, input logic wren, input logic [11:0] addr,
                        input logic [31:0] data);
    bus.p0_req  = req;
    bus.p0_wren = wren;
    bus.p0_addr = addr;
    bus.p0_data = data;
  endtask

  task automatic set_p1(input logic req, input logic wren, input logic lock,
                        input logic [11:0] addr, input logic [31:0] data);
    bus.p1_req  = req;
    bus.p1_wren = wren;
    bus.p1_lock = lock;
    bus.p1_addr = addr;
    bus.p1_data = data;
  endtask

  task automatic preload(input logic [11:0] addr, input logic [31:0] data);
    ld_en   = 1'b1;
    ld_addr = addr;
    ld_data = data;
    tick();
    ld_en   = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    ld_en    = 1'b0;
    ld_addr  = '0;
    ld_data  = '0;
    set_p0(1'b0, 1'b0, 12'h000, 32'h0);
    set_p1(1'b0, 1'b0, 1'b0, 12'h000, 32'h0);

    preload(12'h010, 32'hDEADBEEF);
    preload(12'h001, 32'hA1A1A1A1);
    preload(12'h002, 32'hB2B2B2B2);
    preload(12'h031, 32'hC3C3C3C3);

    // Requests during reset must be masked.
    set_p0(1'b1, 1'b1, 12'h040, 32'h11111111);
    set_p1(1'b1, 1'b1, 1'b0, 12'h041, 32'h22222222);
    #1;
    check("rst_gnt0",   32'(bus.p0_gnt),    32'd0);
    check("rst_gnt1",   32'(bus.p1_gnt),    32'd0);
    check("rst_wren",   32'(bus.mem_wren),  32'd0);
    check("rst_rvalid0", 32'(bus.p0_rvalid), 32'd0);
    check("rst_rvalid1", 32'(bus.p1_rvalid), 32'd0);
    check("rst_q0",     bus.p0_q,           32'd0);
    check("rst_q1",     bus.p1_q,           32'd0);
    set_p0(1'b0, 1'b0, 12'h000, 32'h0);
    set_p1(1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
    tick();
    rst = 1'b0;

    // Single p0 read.
    tick();
    set_p0(1'b1, 1'b0, 12'h010, 32'h0);
    #1;
    check("t1_gnt0", 32'(bus.p0_gnt),     32'd1);
    check("t1_gnt1", 32'(bus.p1_gnt),     32'd0);
    check("t1_addr", 32'(bus.mem_address), 32'h010);
    check("t1_wren", 32'(bus.mem_wren),   32'd0);
    tick();
    set_p0(1'b0, 1'b0, 12'h000, 32'h0);
    #1;
    check("t1_rvalid0", 32'(bus.p0_rvalid), 32'd1);
    check("t1_q0",      bus.p0_q,           32'hDEADBEEF);
    check("t1_rvalid1", 32'(bus.p1_rvalid), 32'd0);
    check("t1_q1",      bus.p1_q,           32'd0);

    // Reset pulse restores last_winner so p0 wins the next tie.
    rst = 1'b1;
    #3;
    rst = 1'b0;

    // Both ports reading continuously.
    tick();
    set_p0(1'b1, 1'b0, 12'h001, 32'h0);
    set_p1(1'b1, 1'b0, 1'b0, 12'h002, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t2_gnt0", 32'(bus.p0_gnt), 32'(c_FIXED || (i % 2 == 0)));
      check("t2_gnt1", 32'(bus.p1_gnt), 32'(!c_FIXED && (i % 2 == 1)));
      if (i > 0) begin
        check("t2_rvalid0", 32'(bus.p0_rvalid), 32'(c_FIXED || (i % 2 == 1)));
        check("t2_q0", bus.p0_q, (c_FIXED || (i % 2 == 1)) ? 32'hA1A1A1A1 : 32'h0);
        check("t2_rvalid1", 32'(bus.p1_rvalid), 32'(!c_FIXED && (i % 2 == 0)));
        check("t2_q1", bus.p1_q, (!c_FIXED && (i % 2 == 0)) ? 32'hB2B2B2B2 : 32'h0);
      end
      tick();
    end
    set_p0(1'b0, 1'b0, 12'h000, 32'h0);
    set_p1(1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
    #1;
    check("t2_last_rvalid1", 32'(bus.p1_rvalid), 32'(!c_FIXED));

    // p1 write followed by p0 read of the same word.
    tick();
    set_p1(1'b1, 1'b1, 1'b0, 12'h020, 32'h12345678);
    #1;
    check("t3_gnt1", 32'(bus.p1_gnt),      32'd1);
    check("t3_wren", 32'(bus.mem_wren),    32'd1);
    check("t3_addr", 32'(bus.mem_address), 32'h020);
    check("t3_data", bus.mem_data,         32'h12345678);
    tick();
    set_p1(1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
    set_p0(1'b1, 1'b0, 12'h020, 32'h0);
    #1;
    check("t3_gnt0",    32'(bus.p0_gnt),    32'd1);
    check("t3_rvalid1", 32'(bus.p1_rvalid), 32'd0);
    tick();
    set_p0(1'b0, 1'b0, 12'h000, 32'h0);
    #1;
    check("t3_rvalid0", 32'(bus.p0_rvalid), 32'd1);
    check("t3_q0",      bus.p0_q,           32'h12345678);

    // Lock: p1 takes three grants while p0 waits.
    tick();
    set_p1(1'b1, 1'b0, 1'b1, 12'h031, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4_gnt1", 32'(bus.p1_gnt), 32'd1);
      check("t4_gnt0", 32'(bus.p0_gnt), 32'd0);
      if (i > 0) begin
        check("t4_q1", bus.p1_q, 32'hC3C3C3C3);
      end
      tick();
      set_p0(1'b1, 1'b0, 12'h030, 32'h0);
    end
    set_p1(1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
    #1;
    check("t4_unlock_gnt0", 32'(bus.p0_gnt),    32'd0);
    check("t4_unlock_rv1",  32'(bus.p1_rvalid), 32'd1);
    tick();
    #1;
    check("t4_after_gnt0", 32'(bus.p0_gnt), 32'd1);
    tick();
    set_p0(1'b0, 1'b0, 12'h000, 32'h0);
    #1;
    check("t4_rvalid0", 32'(bus.p0_rvalid), 32'd1);

    // Reset one cycle after a p0 read grant drops the pending rvalid.
    tick();
    set_p0(1'b1, 1'b0, 12'h010, 32'h0);
    #1;
    check("t5_gnt0", 32'(bus.p0_gnt), 32'd1);
    tick();
    set_p0(1'b0, 1'b0, 12'h000, 32'h0);
    rst = 1'b1;
    #1;
    check("t5_rvalid0", 32'(bus.p0_rvalid), 32'd0);
    check("t5_q0",      bus.p0_q,           32'd0);
    #3;
    rst = 1'b0;

    // Reset while LOCKED returns to ARB with p0 winning the tie.
    tick();
    set_p1(1'b1, 1'b0, 1'b1, 12'h031, 32'h0);
    #1;
    check("t5_lock_gnt1", 32'(bus.p1_gnt), 32'd1);
    tick();
    set_p1(1'b0, 1'b0, 1'b1, 12'h031, 32'h0);
    set_p0(1'b1, 1'b0, 12'h010, 32'h0);
    #1;
    check("t5_locked_gnt0", 32'(bus.p0_gnt), 32'd0);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    set_p1(1'b1, 1'b0, 1'b0, 12'h002, 32'h0);
    #1;
    check("t5_tie_gnt0", 32'(bus.p0_gnt), 32'd1);
    check("t5_tie_gnt1", 32'(bus.p1_gnt), 32'd0);
    tick();
    // p1 still requesting: next winner depends on the tie policy.
    #1;
    check("t5_rv0", 32'(bus.p0_rvalid), 32'd1);
    check("t5_q0b", bus.p0_q,           32'hDEADBEEF);

    // Continuous contention.
    for (int i = 0; i < 4; i++) begin
      check("t6_gnt0", 32'(bus.p0_gnt), 32'(c_FIXED || (i % 2 == 1)));
      check("t6_gnt1", 32'(bus.p1_gnt), 32'(!c_FIXED && (i % 2 == 0)));
      tick();
      #1;
    end
    set_p0(1'b0, 1'b0, 12'h000, 32'h0);
    set_p1(1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_dmem_arbiter
`default_nettype wire
